// File: rtl/ysyx_220066_dmem_resp_if.sv
// rtl/ysyx_220066_dmem_resp_if.sv - memory-stage request/response bundle between the pipeline and the data-memory responder
interface ysyx_220066_dmem_resp_if;
    logic        MemRd;
    logic        MemWr;
    logic [2:0]  MemOp;
    logic [63:0] addr;
    logic [63:0] data_Wr;
    logic        block;
    logic        resp_valid;
    logic [63:0] rdata;
    logic        error;

    // memory stage side: issues requests, observes stall and response
    modport master (
        output MemRd,
        output MemWr,
        output MemOp,
        output addr,
        output data_Wr,
        input  block,
        input  resp_valid,
        input  rdata,
        input  error
    );

    // responder side
    modport slave (
        input  MemRd,
        input  MemWr,
        input  MemOp,
        input  addr,
        input  data_Wr,
        output block,
        output resp_valid,
        output rdata,
        output error
    );
endinterface

// File: rtl/ysyx_220066_dmem_resp.sv
// rtl/ysyx_220066_dmem_resp.sv - word-organised 64-bit data memory responder with wait states; optional DMEM_ALIGN_CHK_EN misalignment fault
module ysyx_220066_dmem_resp #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_220066_dmem_resp_if.slave     bus
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;

    // request copy taken at acceptance; live bus inputs are ignored afterwards
    logic        r_rd;
    logic        r_wr;
    logic [2:0]  r_op;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    logic        r_resp_valid;
    logic [63:0] r_rdata;
    logic        r_error;

    // array contents are deliberately not reset
    logic [63:0] r_mem [DEPTH];

    logic        w_req;
    logic [63:0] w_off;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic [2:0]  w_lane;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_be;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_word;
    logic [63:0] w_shift;
    logic [63:0] w_load;
    logic        w_misalign;
    logic        w_fault;
    logic        w_commit;
    logic        w_do_write;

    assign w_req = bus.MemRd | bus.MemWr;

    // stall while busy, and in the very cycle a request is presented to IDLE
    assign bus.block      = (r_state == BUSY) | ((r_state == IDLE) & w_req);
    assign bus.resp_valid = r_resp_valid;
    assign bus.rdata      = r_rdata;
    assign bus.error      = r_error;

    // unsigned offset: addresses below BASE wrap to huge values and fault
    assign w_off      = r_addr - BASE;
    assign w_in_range = (w_off < SPAN);
    assign w_idx      = w_off[AW+2:3];
    assign w_lane     = w_off[2:0];

    // access width from the low two funct3 bits, same for loads and stores
    always_comb begin
        w_size_mask = 8'h01;
        case (r_op[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // shifting within 8 bits drops enables past the word end, so a straddling
    // store is truncated rather than spilling into the next word
    assign w_be       = w_size_mask << w_lane;
    assign w_wdata_sh = r_wdata << {w_lane, 3'b000};

`ifdef DMEM_ALIGN_CHK_EN
    // offset must be a multiple of the access size
    always_comb begin
        w_misalign = 1'b0;
        case (r_op[1:0])
            2'b01:   w_misalign = w_off[0];
            2'b10:   w_misalign = |w_off[1:0];
            2'b11:   w_misalign = |w_off[2:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = (r_rd & r_wr)
                   | ~w_in_range
                   | (r_rd & (r_op == 3'b111))
                   | (r_wr & r_op[2])
                   | w_misalign;

    // read path: word fetched by index, then the addressed lane moved to bit 0
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    // load extension by funct3
    always_comb begin
        w_load = 64'd0;
        case (r_op)
            3'b000:  w_load = {{56{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_load = {{48{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = {{32{w_shift[31]}}, w_shift[31:0]};
            3'b011:  w_load = w_shift;
            3'b100:  w_load = {56'd0, w_shift[7:0]};
            3'b101:  w_load = {48'd0, w_shift[15:0]};
            3'b110:  w_load = {32'd0, w_shift[31:0]};
            default: w_load = 64'd0;
        endcase
    end

    // the access executes on the BUSY->RESP edge once the wait count is spent
    assign w_commit   = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_do_write = rst & w_commit & r_wr & ~w_fault;

    // control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_op         <= 3'd0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 64'd0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (w_req) begin
                        r_rd    <= bus.MemRd;
                        r_wr    <= bus.MemWr;
                        r_op    <= bus.MemOp;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.data_Wr;
                        r_cnt   <= 4'(LATENCY);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_error      <= w_fault;
                        r_rdata      <= (w_fault | ~r_rd) ? 64'd0 : w_load;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    // single-cycle pulse; requests wait for the next IDLE
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // byte-masked array write, only for a successful store
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// tb/tb_ysyx_220066_dmem_resp.sv - randomized self-checking bench for ysyx_220066_dmem_resp against a byte-level memory model
module tb_ysyx_220066_dmem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT   = 2;

    logic clk;
    logic rst;

    ysyx_220066_dmem_resp_if bus ();

    ysyx_220066_dmem_resp #(
        .DEPTH   (DEPTH),
        .BASE    (BASE),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // byte-addressed reference memory keyed by offset from BASE
    logic [7:0] mem_m [logic [63:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // reference: fault rules, then byte-by-byte read/write limited to the word
    task automatic ref_access(input bit rd, input bit wr, input logic [2:0] op,
                              input logic [63:0] a, input logic [63:0] d,
                              output logic [63:0] r, output bit e);
        logic [63:0] off;
        int size;
        int lane;
        off  = a - BASE;
        size = 1 << op[1:0];
        lane = int'(off % 64'd8);
        r = 64'd0;
        e = 1'b0;
        if (rd && wr) e = 1'b1;
        if (off >= 64'(DEPTH) * 64'd8) e = 1'b1;
        if (rd && op == 3'b111) e = 1'b1;
        if (wr && op[2]) e = 1'b1;
`ifdef DMEM_ALIGN_CHK_EN
        if ((off % 64'(size)) != 64'd0) e = 1'b1;
`endif
        if (e) return;
        if (rd) begin
            for (int i = 0; i < size; i++)
                if (lane + i < 8) r[8*i +: 8] = mem_m[off + 64'(i)];
            if (!op[2] && size < 8 && r[8*size-1])
                for (int i = 8*size; i < 64; i++) r[i] = 1'b1;
        end else begin
            for (int i = 0; i < size; i++)
                if (lane + i < 8) mem_m[off + 64'(i)] = d[8*i +: 8];
        end
    endtask

    // one complete transaction: checks stall window, latency, error and data
    task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] d, output logic [63:0] got_r);
        logic [63:0] exp_r;
        bit          exp_e;
        bit          blk_ok;
        int          n;
        ref_access(rd, wr, op, a, d, exp_r, exp_e);
        @(negedge clk);
        bus.MemRd = rd; bus.MemWr = wr; bus.MemOp = op; bus.addr = a; bus.data_Wr = d;
        #1;
        chk({tag, ".block0"}, 64'(bus.block), 64'd1);
        blk_ok = 1'b1;
        n = 1;
        while (n <= 40) begin
            @(negedge clk);
            if (n == 1) begin
                // drop the request and scramble the bus: the latched copy must be used
                bus.MemRd = 1'b0; bus.MemWr = 1'b0; bus.MemOp = 3'($urandom);
                bus.addr = {$urandom, $urandom}; bus.data_Wr = {$urandom, $urandom};
            end
            #1;
            if (bus.resp_valid) break;
            if (!bus.block) blk_ok = 1'b0;
            n++;
        end
        got_r = bus.rdata;
        chk({tag, ".lat"},     64'(n), 64'(LAT + 2));
        chk({tag, ".blk_win"}, 64'(blk_ok), 64'd1);
        chk({tag, ".blk_rsp"}, 64'(bus.block), 64'd0);
        chk({tag, ".err"},     64'(bus.error), 64'(exp_e));
        chk({tag, ".rdata"},   bus.rdata, exp_r);
        @(negedge clk);
        #1;
        chk({tag, ".pulse"},   64'(bus.resp_valid), 64'd0);
    endtask

    logic [63:0] r, prev0, w1, w2;
    bit          rd_r, wr_r;
    logic [2:0]  op_r;
    logic [63:0] a_r;
    int          sel;
    int          word;
    bit          rv_seen;

    initial begin
        rst = 1'b0;
        bus.MemRd = 1'b0; bus.MemWr = 1'b0; bus.MemOp = 3'd0; bus.addr = 64'd0; bus.data_Wr = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst.rdata",      bus.rdata, 64'd0);
        chk("rst.error",      64'(bus.error), 64'd0);
        chk("rst.block",      64'(bus.block), 64'd0);

        // fill the working window (words 0..7 and the last word)
        for (int i = 0; i < 9; i++) begin
            word = (i == 8) ? DEPTH - 1 : i;
            access("init", 1'b0, 1'b1, 3'b011, BASE + 64'(word) * 8, {$urandom, $urandom}, r);
        end

        // doubleword store then load
        access("sd", 1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h1122334455667788, r);
        chk("sd.rdata0", r, 64'd0);
        access("ld", 1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, r);
        chk("ld.const", r, 64'h1122334455667788);

        // byte store into lane 3, then signed/unsigned/full loads
        access("sb", 1'b0, 1'b1, 3'b000, 64'h8000_000B, 64'h0000_0000_0000_00FF, r);
        access("lb", 1'b1, 1'b0, 3'b000, 64'h8000_000B, 64'd0, r);
        chk("lb.const", r, 64'hFFFF_FFFF_FFFF_FFFF);
        access("lbu", 1'b1, 1'b0, 3'b100, 64'h8000_000B, 64'd0, r);
        chk("lbu.const", r, 64'h0000_0000_0000_00FF);
        access("ld2", 1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, r);
        chk("ld2.const", r, 64'h1122_3344_FF66_7788);

        // out-of-range faults leave memory unchanged
        access("ld0a", 1'b1, 1'b0, 3'b011, BASE, 64'd0, prev0);
        access("lw_low", 1'b1, 1'b0, 3'b010, 64'h7FFF_FFFC, 64'd0, r);
        access("ld_top", 1'b1, 1'b0, 3'b011, BASE + 64'(DEPTH) * 8, 64'd0, r);
        access("sd_both", 1'b1, 1'b1, 3'b011, BASE, 64'hDEAD_BEEF_0BAD_F00D, r);
        access("ld_op7", 1'b1, 1'b0, 3'b111, BASE, 64'd0, r);
        access("ld0b", 1'b1, 1'b0, 3'b011, BASE, 64'd0, r);
        chk("ld0b.same", r, prev0);

        // reset during BUSY of a store: no response, no write
        access("ld2a", 1'b1, 1'b0, 3'b011, BASE + 16, 64'd0, w2);
        @(negedge clk);
        bus.MemRd = 1'b0; bus.MemWr = 1'b1; bus.MemOp = 3'b011; bus.addr = BASE + 16; bus.data_Wr = ~w2;
        @(negedge clk);
        bus.MemWr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid) rv_seen = 1'b1;
        end
        chk("rstmid.no_resp", 64'(rv_seen), 64'd0);
        access("ld2b", 1'b1, 1'b0, 3'b011, BASE + 16, 64'd0, r);
        chk("rstmid.unchanged", r, w2);

        // misaligned accesses: fault in the checked build, truncated otherwise
        access("ld0c", 1'b1, 1'b0, 3'b011, BASE, 64'd0, prev0);
        access("ld1c", 1'b1, 1'b0, 3'b011, BASE + 8, 64'd0, w1);
`ifdef DMEM_ALIGN_CHK_EN
        access("sh_mis", 1'b0, 1'b1, 3'b001, BASE + 1, 64'h0000_0000_0000_1234, r);
        access("ld0d", 1'b1, 1'b0, 3'b011, BASE, 64'd0, r);
        chk("sh_mis.nowrite", r, prev0);
`else
        access("sw_ovf", 1'b0, 1'b1, 3'b010, BASE + 6, 64'h0000_0000_AABB_CCDD, r);
        access("ld0d", 1'b1, 1'b0, 3'b011, BASE, 64'd0, r);
        chk("sw_ovf.word0", r, {16'hCCDD, prev0[47:0]});
        access("ld1d", 1'b1, 1'b0, 3'b011, BASE + 8, 64'd0, r);
        chk("sw_ovf.word1", r, w1);
`endif

        // randomized traffic over the window plus fault addresses
        for (int t = 0; t < 200; t++) begin
            sel = $urandom_range(0, 9);
            rd_r = (sel == 0) || (sel < 5);
            wr_r = (sel == 0) || (sel >= 5);
            op_r = 3'($urandom_range(0, 7));
            word = $urandom_range(0, 8);
            if (word == 8) word = DEPTH - 1;
            a_r = BASE + 64'(word) * 8 + 64'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0) a_r = BASE - 64'($urandom_range(1, 64));
            else if (sel == 1) a_r = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 64));
            access("rnd", rd_r, wr_r, op_r, a_r, {$urandom, $urandom}, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
